part_vector_engine: RTL and testbench
=====================================

Name: part_vector_engine

Overview:
- Parametrised test-vector engine for the part tester.
- Consumes a byte stream from the UART receiver and assembles packets of PI stimulus, expected PO and PO compare mask.
- Drives the part's primary inputs, waits a programmable settle time, samples the primary outputs and compares under mask.
- Returns a pass/fail byte (optionally followed by the captured POs) over the UART transmit handshake, and keeps vector and failure counters for LEDs/7-segment debug.

Parameters:
- NPIS, 14, number of part primary inputs (1..64)
- NPOS, 11, number of part primary outputs (1..64)
- SETTLE, 4, clock cycles between PI update and PO sample (1..255)
- TIMEOUT, 1000000, idle cycles allowed between bytes of one packet before it is discarded
- CNT_W, 16, width of vector and fail counters

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- new_rx_data  in  1  one-cycle strobe, rx_data valid
- tx_data_o  out  8  byte to transmit
- tx_start_o  out  1  one-cycle transmit request
- tx_ready_i  in  1  transmitter idle
- clr_cnt_i  in  1  pulse: clear counters and overrun flag
- part_pis_o  out  [1:NPIS]  stimulus to part
- part_pos_i  in  [1:NPOS]  part response
- vec_cnt_o  out  CNT_W  vectors completed, saturating
- fail_cnt_o  out  CNT_W  failing vectors, saturating
- busy_o  out  1  high outside S_RX-with-zero-bytes
- overrun_o  out  1  sticky: byte arrived while not receiving

Behaviour:
- Interface: one clock `clk`; reset `rstn` is asynchronous and active-low. Reset clears all state and outputs to 0 and the FSM enters S_RX with the byte count at 0.
- Packet format: PB=ceil(NPIS/8) PI bytes, OB=ceil(NPOS/8) expected bytes, then OB mask bytes. Total NB=PB+2*OB; the default is 6.
- Bit order: the first byte of each field carries index 1 in bit7. Padding bits sit in the low bits of the last byte and are ignored.
- S_RX: each new_rx_data shifts the byte into the packet register and increments the count.
  - If TIMEOUT cycles pass with count>0 and no byte, the count resets to 0 (packet dropped, no response).
  - When the count reaches NB, go to S_SETTLE.
- S_SETTLE: on the entry cycle, part_pis_o is loaded from the PI field. part_pis_o is otherwise stable and holds the last vector.
  - Count SETTLE cycles, then S_CMP.
- S_CMP (1 cycle): sample part_pos_i.
  - fail = |((po ^ exp) & mask); mask bit 1 = compare.
  - vec_cnt +1 and fail_cnt +fail, both saturating at 2^CNT_W-1.
  - Go to S_TX.
- S_TX: the response byte is 0x50 'P' or 0x46 'F'.
- TX handshake:
  - tx_start_o pulses for exactly one cycle, only while tx_ready_i=1, with tx_data_o valid in the same cycle.
  - No further pulse until tx_ready_i has been sampled 0 and then 1 again.
  - tx_data_o holds its value until the next pulse.
- After the last byte is accepted (tx_ready_i seen 0), the FSM returns to S_RX with count 0.
- Bytes arriving in any state other than S_RX are dropped and set overrun_o.
- clr_cnt_i zeroes both counters and overrun_o. If it coincides with an increment or overrun event, the clear wins.
- Reset mid-packet or mid-TX: immediate abort. part_pis_o=0, no pending tx pulse.
- Latency: the last byte strobe to tx_start_o is SETTLE+2 cycles when tx_ready_i=1.

Optional Feature:
- PART_VEC_ECHO_PO_EN defined: after the result byte, the engine sends OB bytes of captured POs in the same bit order as the expected field, with zero padding. The response is 1+OB bytes.
- Undefined: only the result byte is sent, and the capture register is still used for the compare.

Test Plan:
- Defaults, part_pos_i looped to part_pis_o[1:11]. Send A5 3C A5 20 FF E0 -> part_pis_o=14'b10100101001111, tx 0x50, vec_cnt=1, fail_cnt=0.
- Same loopback, expected 00 00, mask FF E0 -> tx 0x46, fail_cnt=1. Mask 00 00 -> tx 0x50.
- Send 3 bytes, idle TIMEOUT+1 cycles, then send a full valid 6-byte packet -> exactly one response, matching the second packet only.
- Hold tx_ready_i=0 for 500 cycles after the packet -> no tx_start_o. Release -> one pulse. Inject a byte during the wait -> overrun_o=1, and the byte is ignored.
- With PART_VEC_ECHO_PO_EN and po=11'h5A3 -> tx sequence 0x50/0x46, 0xB4, 0x60. Each pulse waits for the ready 0->1 cycle.
- Assert rstn=0 at SETTLE cycle 2 -> part_pis_o=0, no tx, counters 0. Then clr_cnt_i coinciding with a fail increment -> counters read 0.

Source files
------------

// File: rtl/part_vector_engine.sv
// Byte-stream driven test-vector engine: assembles PI/expected/mask packets, applies them,
// compares the part response under mask and replies over UART. Define PART_VEC_ECHO_PO_EN to echo captured POs.
module part_vector_engine #(
  parameter int NPIS    = 14,
  parameter int NPOS    = 11,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1000000,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [7:0]       rx_data,
  input  logic             new_rx_data,
  output logic [7:0]       tx_data_o,
  output logic             tx_start_o,
  input  logic             tx_ready_i,
  input  logic             clr_cnt_i,
  output logic [1:NPIS]    part_pis_o,
  input  logic [1:NPOS]    part_pos_i,
  output logic [CNT_W-1:0] vec_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic             busy_o,
  output logic             overrun_o
);

  localparam int PB    = (NPIS + 7) / 8;
  localparam int OB    = (NPOS + 7) / 8;
  localparam int NB    = PB + 2 * OB;
  localparam int PKT_W = NB * 8;
`ifdef PART_VEC_ECHO_PO_EN
  localparam int OW    = OB * 8;
  localparam int NTX   = 1 + OB;
`else
  localparam int NTX   = 1;
`endif
  localparam int CW    = $clog2(NB + 1);
  localparam int IW    = $clog2(TIMEOUT + 1);
  localparam int XW    = $clog2(NTX + 1);

  localparam logic [7:0] RESP_P = 8'h50;
  localparam logic [7:0] RESP_F = 8'h46;

  typedef enum logic [1:0] {
    S_RX,
    S_SETTLE,
    S_CMP,
    S_TX
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [IW-1:0]     idle_q;
  logic [7:0]        settle_q;
  logic [PKT_W-1:0]  pkt_q;
  logic [1:NPIS]     pis_q;
  logic [7:0]        tx_data_q;
  logic              tx_start_q;
  logic              need_low_q;
  logic [XW-1:0]     tx_idx_q;
  logic              result_q;
  logic [CNT_W-1:0]  vec_q;
  logic [CNT_W-1:0]  fail_q;
  logic              overrun_q;
`ifdef PART_VEC_ECHO_PO_EN
  logic [OW-1:0]     po_pad_q;
  logic [OW-1:0]     po_sh;
`endif

  // First packet byte ends up in the top byte; mask field is the last OB bytes.
  logic [NPOS-1:0] exp_v;
  logic [NPOS-1:0] mask_v;
  logic [NPOS-1:0] po_v;
  logic            cmp_fail;
  logic [7:0]      tx_byte;

  assign exp_v    = pkt_q[2*OB*8-1 -: NPOS];
  assign mask_v   = pkt_q[OB*8-1 -: NPOS];
  assign po_v     = part_pos_i;
  assign cmp_fail = |((po_v ^ exp_v) & mask_v);

  always_comb begin
    tx_byte = result_q ? RESP_F : RESP_P;
`ifdef PART_VEC_ECHO_PO_EN
    po_sh = po_pad_q >> (8 * (OB - int'(tx_idx_q)));
    if (tx_idx_q != '0) tx_byte = po_sh[7:0];
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_RX;
      cnt_q      <= '0;
      idle_q     <= '0;
      settle_q   <= '0;
      pkt_q      <= '0;
      pis_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      need_low_q <= 1'b0;
      tx_idx_q   <= '0;
      result_q   <= 1'b0;
      vec_q      <= '0;
      fail_q     <= '0;
      overrun_q  <= 1'b0;
`ifdef PART_VEC_ECHO_PO_EN
      po_pad_q   <= '0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        S_RX: begin
          if (new_rx_data) begin
            pkt_q  <= {pkt_q[PKT_W-9:0], rx_data};
            idle_q <= '0;
            if (cnt_q == CW'(NB - 1)) begin
              cnt_q    <= '0;
              settle_q <= '0;
              state_q  <= S_SETTLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (cnt_q != '0) begin
            if (idle_q == IW'(TIMEOUT - 1)) begin
              cnt_q  <= '0;
              idle_q <= '0;
            end else begin
              idle_q <= idle_q + 1'b1;
            end
          end else begin
            idle_q <= '0;
          end
        end

        S_SETTLE: begin
          if (settle_q == '0) pis_q <= pkt_q[PKT_W-1 -: NPIS];
          if (settle_q == 8'(SETTLE - 1)) begin
            settle_q <= '0;
            state_q  <= S_CMP;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end

        S_CMP: begin
          // The result byte is launched straight from the compare so the
          // strobe-to-start latency stays at SETTLE+2.
          result_q <= cmp_fail;
`ifdef PART_VEC_ECHO_PO_EN
          po_pad_q <= OW'(po_v) << (OW - NPOS);
`endif
          if (vec_q != '1) vec_q <= vec_q + 1'b1;
          if (cmp_fail && (fail_q != '1)) fail_q <= fail_q + 1'b1;
          tx_idx_q <= '0;
          if (tx_ready_i) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= cmp_fail ? RESP_F : RESP_P;
            tx_idx_q   <= XW'(1);
            need_low_q <= 1'b1;
          end
          state_q <= S_TX;
        end

        S_TX: begin
          if (need_low_q) begin
            if (!tx_ready_i) begin
              need_low_q <= 1'b0;
              if (tx_idx_q == XW'(NTX)) begin
                cnt_q   <= '0;
                state_q <= S_RX;
              end
            end
          end else if (tx_ready_i) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= tx_byte;
            tx_idx_q   <= tx_idx_q + 1'b1;
            need_low_q <= 1'b1;
          end
        end

        default: state_q <= S_RX;
      endcase

      if (new_rx_data && (state_q != S_RX)) overrun_q <= 1'b1;

      if (clr_cnt_i) begin
        vec_q     <= '0;
        fail_q    <= '0;
        overrun_q <= 1'b0;
      end
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_start_o = tx_start_q;
  assign part_pis_o = pis_q;
  assign vec_cnt_o  = vec_q;
  assign fail_cnt_o = fail_q;
  assign overrun_o  = overrun_q;
  assign busy_o     = (state_q != S_RX) || (cnt_q != '0);

endmodule

// File: tb/tb_part_vector_engine.sv
// Directed bench for part_vector_engine: table of packets with hand-computed responses
// plus sequences for timeout, TX back-pressure/overrun, latency, reset abort and clear priority.
module tb_part_vector_engine;

  localparam int NPIS    = 14;
  localparam int NPOS    = 11;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 200;
  localparam int CNT_W   = 16;
`ifdef PART_VEC_ECHO_PO_EN
  localparam int NTX = 3;
`else
  localparam int NTX = 1;
`endif

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [7:0]       rx_data = '0;
  logic             new_rx_data = 1'b0;
  logic [7:0]       tx_data_o;
  logic             tx_start_o;
  logic             tx_ready_i = 1'b1;
  logic             clr_cnt_i = 1'b0;
  logic [1:NPIS]    part_pis_o;
  logic [1:NPOS]    part_pos_i;
  logic [CNT_W-1:0] vec_cnt_o;
  logic [CNT_W-1:0] fail_cnt_o;
  logic             busy_o;
  logic             overrun_o;

  logic             use_loop = 1'b1;
  logic [1:NPOS]    po_force = '0;

  assign part_pos_i = use_loop ? part_pis_o[1:NPOS] : po_force;

  part_vector_engine #(
    .NPIS(NPIS), .NPOS(NPOS), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .tx_data_o(tx_data_o), .tx_start_o(tx_start_o), .tx_ready_i(tx_ready_i),
    .clr_cnt_i(clr_cnt_i), .part_pis_o(part_pis_o), .part_pos_i(part_pos_i),
    .vec_cnt_o(vec_cnt_o), .fail_cnt_o(fail_cnt_o), .busy_o(busy_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] rxq[$];
  int         pulses = 0;
  int         tx_busy = 0;
  bit         tx_hold = 1'b0;
  logic       prev_start = 1'b0;

  // UART transmitter model: ready drops for a few cycles after each start pulse.
  always @(negedge clk) begin
    if (tx_start_o === 1'b1) begin
      rxq.push_back(tx_data_o);
      pulses++;
      checks++;
      if (!(tx_ready_i && !prev_start)) begin
        errors++;
        $display("FAIL tx_handshake: start with ready=%0b prev_start=%0b, required ready=1 prev_start=0",
                 tx_ready_i, prev_start);
      end
      tx_busy = 3;
    end else if (tx_busy > 0) begin
      tx_busy--;
    end
    prev_start = tx_start_o;
    tx_ready_i = !tx_hold && (tx_busy == 0);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data     = b;
    new_rx_data = 1'b1;
    @(negedge clk);
    new_rx_data = 1'b0;
  endtask

  task automatic send_packet(input logic [47:0] pk);
    for (int unsigned i = 0; i < 6; i++) begin
      send_byte(pk[47-8*i -: 8]);
      if (i != 5) repeat (2) @(negedge clk);
    end
  endtask

  task automatic wait_resp(input int n);
    int k;
    k = 0;
    while ((rxq.size() < n || busy_o) && k < 400) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 400) begin
      errors++;
      $display("FAIL resp_wait: got %0d bytes busy=%0b after 400 cycles, expected %0d bytes idle",
               rxq.size(), busy_o, n);
    end
    repeat (10) @(negedge clk);
    chk("resp_count", rxq.size(), n);
  endtask

  typedef struct {
    logic [47:0] pk;
    logic [13:0] pis;
    logic        fail;
    logic [15:0] vec;
    logic [15:0] fcnt;
  } vec_t;

  vec_t       tbl[7];
  int         exp_vec;
  int         exp_fail;
  int         k;
  int         p0;
  logic [15:0] echo;

  initial begin
    tbl[0] = '{48'hA53CA520FFE0, 14'h294F, 1'b0, 16'd1, 16'd0};
    tbl[1] = '{48'hA53C0000FFE0, 14'h294F, 1'b1, 16'd2, 16'd1};
    tbl[2] = '{48'hA53C00000000, 14'h294F, 1'b0, 16'd3, 16'd1};
    tbl[3] = '{48'hFFFC00000020, 14'h3FFF, 1'b1, 16'd4, 16'd2};
    tbl[4] = '{48'h0000FFE0FFE0, 14'h0000, 1'b1, 16'd5, 16'd3};
    tbl[5] = '{48'h12341220FFE0, 14'h048D, 1'b0, 16'd6, 16'd3};
    tbl[6] = '{48'h0000001FFFFF, 14'h0000, 1'b0, 16'd7, 16'd3};

    #12;
    chk("rst_pis", part_pis_o, 0);
    chk("rst_tx_start", tx_start_o, 0);
    chk("rst_vec", vec_cnt_o, 0);
    chk("rst_fail", fail_cnt_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_overrun", overrun_o, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      rxq.delete();
      send_packet(tbl[i].pk);
      wait_resp(NTX);
      chk($sformatf("v%0d_pis", i), part_pis_o, tbl[i].pis);
      chk($sformatf("v%0d_resp", i), rxq[0], tbl[i].fail ? 8'h46 : 8'h50);
      chk($sformatf("v%0d_vec", i), vec_cnt_o, tbl[i].vec);
      chk($sformatf("v%0d_fail", i), fail_cnt_o, tbl[i].fcnt);
`ifdef PART_VEC_ECHO_PO_EN
      echo = {tbl[i].pis[13:3], 5'b0};
      chk($sformatf("v%0d_echo0", i), rxq[1], echo[15:8]);
      chk($sformatf("v%0d_echo1", i), rxq[2], echo[7:0]);
`endif
    end
    exp_vec  = 7;
    exp_fail = 3;

    // Strobe-to-start latency.
    rxq.delete();
    for (int unsigned i = 0; i < 5; i++) begin
      send_byte(tbl[0].pk[47-8*i -: 8]);
      repeat (2) @(negedge clk);
    end
    send_byte(tbl[0].pk[7:0]);
    k = 0;
    while (tx_start_o !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k + 1, SETTLE + 2);
    wait_resp(NTX);
    exp_vec++;
    chk("lat_vec", vec_cnt_o, exp_vec);

    // Partial packet is dropped after TIMEOUT idle cycles.
    rxq.delete();
    send_byte(8'h11); repeat (2) @(negedge clk);
    send_byte(8'h22); repeat (2) @(negedge clk);
    send_byte(8'h33);
    repeat (TIMEOUT + 1) @(negedge clk);
    chk("to_busy", busy_o, 0);
    chk("to_no_resp", rxq.size(), 0);
    send_packet(tbl[1].pk);
    wait_resp(NTX);
    exp_vec++;
    exp_fail++;
    chk("to_pis", part_pis_o, 14'h294F);
    chk("to_resp", rxq[0], 8'h46);
    chk("to_vec", vec_cnt_o, exp_vec);
    chk("to_fail", fail_cnt_o, exp_fail);

    // Back-pressure: no start while ready low, byte during wait sets overrun.
    rxq.delete();
    tx_hold = 1'b1;
    repeat (2) @(negedge clk);
    p0 = pulses;
    send_packet(tbl[0].pk);
    repeat (100) @(negedge clk);
    send_byte(8'hAA);
    repeat (400) @(negedge clk);
    chk("hold_no_pulse", pulses - p0, 0);
    chk("hold_busy", busy_o, 1);
    chk("hold_overrun", overrun_o, 1);
    tx_hold = 1'b0;
    wait_resp(NTX);
    exp_vec++;
    chk("hold_resp", rxq[0], 8'h50);
    chk("hold_vec", vec_cnt_o, exp_vec);
    chk("hold_data_held", tx_data_o, rxq[NTX-1]);

    @(negedge clk);
    clr_cnt_i = 1'b1;
    @(negedge clk);
    clr_cnt_i = 1'b0;
    chk("clr_vec", vec_cnt_o, 0);
    chk("clr_fail", fail_cnt_o, 0);
    chk("clr_overrun", overrun_o, 0);

    // Forced response 0x5A3 against expected B4 60.
    use_loop = 1'b0;
    po_force = 11'h5A3;
    rxq.delete();
    send_packet(48'h0000B460FFE0);
    wait_resp(NTX);
    chk("po_pass", rxq[0], 8'h50);
    rxq.delete();
    send_packet(48'h00000000FFE0);
    wait_resp(NTX);
    chk("po_fail", rxq[0], 8'h46);
`ifdef PART_VEC_ECHO_PO_EN
    chk("po_echo0", rxq[1], 8'hB4);
    chk("po_echo1", rxq[2], 8'h60);
`endif
    chk("po_vec", vec_cnt_o, 2);
    chk("po_fail_cnt", fail_cnt_o, 1);
    use_loop = 1'b1;

    // Asynchronous reset two cycles into the settle window.
    rxq.delete();
    p0 = pulses;
    for (int unsigned i = 0; i < 5; i++) begin
      send_byte(tbl[3].pk[47-8*i -: 8]);
      repeat (2) @(negedge clk);
    end
    send_byte(tbl[3].pk[7:0]);
    repeat (2) @(negedge clk);
    chk("rst_mid_loaded", part_pis_o, 14'h3FFF);
    rstn = 1'b0;
    #1;
    chk("rst_mid_pis", part_pis_o, 0);
    chk("rst_mid_vec", vec_cnt_o, 0);
    chk("rst_mid_fail", fail_cnt_o, 0);
    chk("rst_mid_start", tx_start_o, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (30) @(negedge clk);
    chk("rst_mid_no_tx", pulses - p0, 0);
    chk("rst_mid_busy", busy_o, 0);

    // Clear coinciding with a failing compare.
    rxq.delete();
    for (int unsigned i = 0; i < 5; i++) begin
      send_byte(tbl[1].pk[47-8*i -: 8]);
      repeat (2) @(negedge clk);
    end
    send_byte(tbl[1].pk[7:0]);
    repeat (4) @(negedge clk);
    clr_cnt_i = 1'b1;
    @(negedge clk);
    clr_cnt_i = 1'b0;
    wait_resp(NTX);
    chk("clr_cmp_resp", rxq[0], 8'h46);
    chk("clr_cmp_vec", vec_cnt_o, 0);
    chk("clr_cmp_fail", fail_cnt_o, 0);

    rxq.delete();
    send_packet(tbl[0].pk);
    wait_resp(NTX);
    chk("final_vec", vec_cnt_o, 1);
    chk("final_fail", fail_cnt_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
